// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, access sizes and FSM states for the LSU.
// LSU_MISALIGNED_EN adds the second-beat states REQ1/WAIT1.
package lsu_pkg;

    localparam int ADDR_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
`ifdef LSU_MISALIGNED_EN
        REQ1,
        WAIT1,
`endif
        RESP
    } state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (!we && (f3 == F3_BU || f3 == F3_HU));
    endfunction

    function automatic size_t size_of(input logic [1:0] f);
        size_t s;
        unique case (f)
            2'b00:   s = SZ_B;
            2'b01:   s = SZ_H;
            default: s = SZ_W;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response and data-memory bus of the LSU.
// master = the LSU, slave = core plus memory environment.
interface lsu_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane strobes, store data shifting and load extraction.
// Purely combinational; beat selects the low or high word of the lane map.
module lsu_align import lsu_pkg::*; (
    input  size_t       size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic        beat,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_beat,
    output logic [31:0] ldata
);

    logic [3:0]  base;
    logic [7:0]  strb8;
    logic [63:0] wide;
    logic [31:0] word;

    // lane mask for the access size before shifting
    always_comb begin
        base = 4'b1111;
        unique case (size)
            SZ_B:    base = 4'b0001;
            SZ_H:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
    end

    assign strb8      = {4'b0000, base} << off;
    assign wide       = {32'b0, wdata} << {off, 3'b000};
    assign strb       = beat ? strb8[7:4] : strb8[3:0];
    assign wdata_beat = beat ? wide[63:32] : wide[31:0];
    assign word       = 32'(rdata >> {off, 3'b000});

    // truncate to access size and sign- or zero-extend
    always_comb begin
        ldata = word;
        unique case (size)
            SZ_B:    ldata = {{24{word[7] & ~uns}}, word[7:0]};
            SZ_H:    ldata = {{16{word[15] & ~uns}}, word[15:0]};
            default: ldata = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core-side load/store front end to a granted data memory.
// LSU_MISALIGNED_EN enables two-beat word-crossing accesses.
module load_store_unit import lsu_pkg::*; (
    input logic    clk,
    input logic    rst_n,
    lsu_if.master  bus
);

    state_t            state_q;
    state_t            state_d;
    logic              init_q;
    logic              we_q;
    logic              uns_q;
    size_t             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              bad;
    logic              beat;
    logic              done;
    logic              issue;
    size_t             size_in;
    logic [1:0]        off_in;
    logic [ADDR_W-1:0] beat_addr;
    logic [63:0]       rd64;
    logic [3:0]        strb;
    logic [31:0]       wd_beat;
    logic [31:0]       ldata;

`ifdef LSU_MISALIGNED_EN
    logic              cross_in;
    logic              cross_q;
    logic [31:0]       beat0_q;
`endif

    assign size_in = size_of(bus.req_funct3[1:0]);
    assign off_in  = bus.req_addr[1:0];
    assign accept  = bus.req_valid && init_q && (state_q == IDLE);

`ifdef LSU_MISALIGNED_EN
    assign cross_in = (size_in == SZ_H && off_in == 2'd3) ||
                      (size_in == SZ_W && off_in != 2'd0);
    assign bad  = !f3_legal(bus.req_we, bus.req_funct3);
    assign beat = (state_q == REQ1);
    assign rd64 = (state_q == WAIT1) ? {bus.mem_rdata, beat0_q}
                                     : {32'b0, bus.mem_rdata};
    assign done = bus.mem_rvalid &&
                  ((state_q == WAIT0 && !cross_q) || state_q == WAIT1);
`else
    assign bad  = !f3_legal(bus.req_we, bus.req_funct3) ||
                  (size_in == SZ_H && off_in[0]) ||
                  (size_in == SZ_W && off_in != 2'd0);
    assign beat = 1'b0;
    assign rd64 = {32'b0, bus.mem_rdata};
    assign done = bus.mem_rvalid && (state_q == WAIT0);
`endif

    assign beat_addr = {addr_q[ADDR_W-1:2], 2'b00} +
                       {{(ADDR_W-3){1'b0}}, beat, 2'b00};

    lsu_align u_align (
        .size       (size_q),
        .uns        (uns_q),
        .off        (addr_q[1:0]),
        .beat       (beat),
        .wdata      (wdata_q),
        .rdata      (rd64),
        .strb       (strb),
        .wdata_beat (wd_beat),
        .ldata      (ldata)
    );

    // state register; init_q holds ready low for the first cycle out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    // next-state logic and memory request qualifier
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE:  if (accept) state_d = bad ? RESP : REQ0;
            REQ0: begin
                issue = 1'b1;
                if (bus.mem_gnt) state_d = WAIT0;
            end
            WAIT0: if (bus.mem_rvalid) begin
`ifdef LSU_MISALIGNED_EN
                state_d = cross_q ? REQ1 : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            REQ1: begin
                issue = 1'b1;
                if (bus.mem_gnt) state_d = WAIT1;
            end
            WAIT1: if (bus.mem_rvalid) state_d = RESP;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = init_q && (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_req   = issue;
    assign bus.mem_we    = issue & we_q;
    assign bus.mem_addr  = issue ? beat_addr : '0;
    assign bus.mem_wdata = issue ? wd_beat : '0;
    assign bus.mem_wstrb = issue ? strb : 4'b0000;

    // request latch and beat-0 read capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LSU_MISALIGNED_EN
            cross_q <= 1'b0;
            beat0_q <= '0;
`endif
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_funct3[2];
                size_q  <= size_in;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
`ifdef LSU_MISALIGNED_EN
                cross_q <= cross_in;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            if (state_q == WAIT0 && bus.mem_rvalid) beat0_q <= bus.mem_rdata;
`endif
        end
    end

    // response registers, nonzero only during the RESP cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (accept && bad) err_q <= 1'b1;
            else if (done && !we_q) rdata_q <= ldata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random loads/stores checked against a
// byte-addressed memory model; follows LSU_MISALIGNED_EN when defined.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    bit [7:0] bmem [bit [31:0]];

    lsu_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [7:0] rd_byte(input bit [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a[7:0] ^ 8'h5a;
    endfunction

    function automatic bit [31:0] rd_word(input bit [31:0] a);
        bit [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rd_byte(a + 32'(i));
        return w;
    endfunction

    task automatic set_word(input bit [31:0] a, input bit [31:0] w);
        for (int i = 0; i < 4; i++) bmem[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic run_op(input bit we, input bit [2:0] f3,
                          input bit [31:0] addr, input bit [31:0] wd,
                          input int gdel, input int rdel,
                          output bit [31:0] got_rd, output bit got_err);
        int nbytes, off, nb, k, gw, rw, beat, exp_rsp, idx;
        bit err, want_req, waiting, done;
        bit [31:0] w0, exp_rd, ea, ewd;
        bit [3:0] es;

        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off    = int'(addr[1:0]);
        err    = !((f3 inside {3'd0, 3'd1, 3'd2}) ||
                   (!we && (f3 inside {3'd4, 3'd5})));
`ifndef LSU_MISALIGNED_EN
        if (addr % nbytes != 0) err = 1'b1;
`endif
        nb = (off + nbytes > 4) ? 2 : 1;
        w0 = addr & ~32'd3;
        exp_rd = '0;
        if (!we && !err) begin
            for (int i = 0; i < nbytes; i++)
                exp_rd[8*i +: 8] = rd_byte(addr + 32'(i));
            if (!f3[2] && exp_rd[8*nbytes-1])
                for (int i = nbytes; i < 4; i++) exp_rd[8*i +: 8] = 8'hff;
        end

        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        for (int t = 0; t < 4 && !bus.req_ready; t++) begin
            @(posedge clk); #1;
        end
        chk("req_ready", 32'(bus.req_ready), 32'd1);

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        want_req = !err;
        waiting  = 1'b0;
        done     = 1'b0;
        beat     = 0;
        rw       = 0;
        exp_rsp  = err ? 1 : -1;
        gw       = (gdel < 0) ? int'($urandom_range(0, 2)) : gdel;
        got_rd   = '0;
        got_err  = 1'b0;

        for (k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #1;
            bus.req_valid  = 1'b0;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
            chk("mem_req", 32'(bus.mem_req), 32'(want_req));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(k == exp_rsp));
            if (bus.rsp_valid) begin
                got_rd  = bus.rsp_rdata;
                got_err = bus.rsp_err;
                chk("rsp_err", 32'(bus.rsp_err), 32'(err));
                chk("rsp_rdata", bus.rsp_rdata, exp_rd);
                done = 1'b1;
            end else begin
                chk("rsp_idle", bus.rsp_rdata | 32'(bus.rsp_err), 32'd0);
            end
            if (want_req && bus.mem_req) begin
                ea  = w0 + 32'(4 * beat);
                ewd = '0;
                es  = '0;
                for (int j = 0; j < 4; j++) begin
                    idx = 4 * beat + j - off;
                    if (idx >= 0 && idx < 4) ewd[8*j +: 8] = wd[8*idx +: 8];
                    if (idx >= 0 && idx < nbytes) es[j] = 1'b1;
                end
                chk("mem_addr", bus.mem_addr, ea);
                chk("mem_we", 32'(bus.mem_we), 32'(we));
                chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(es));
                chk("mem_wdata", bus.mem_wdata, ewd);
                if (gw == 0) begin
                    bus.mem_gnt = 1'b1;
                    want_req = 1'b0;
                    waiting  = 1'b1;
                    rw = (rdel < 0) ? int'($urandom_range(0, 2)) : rdel;
                end else begin
                    gw--;
                end
            end else if (waiting) begin
                if (rw == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = we ? $urandom : rd_word(w0 + 32'(4 * beat));
                    waiting = 1'b0;
                    beat++;
                    if (beat < nb) begin
                        want_req = 1'b1;
                        gw = (gdel < 0) ? int'($urandom_range(0, 2)) : gdel;
                    end else begin
                        exp_rsp = k + 1;
                    end
                end else begin
                    rw--;
                end
            end
        end
        if (!done) chk("rsp_timeout", 32'd0, 32'd1);
        if (we && !err)
            for (int i = 0; i < nbytes; i++)
                bmem[addr + 32'(i)] = wd[8*i +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit [31:0] rd;
        bit        er;
        bit [31:0] a;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        rst_n = 1'b1;
        chk("first_ready", 32'(bus.req_ready), 32'd0);

        run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, rd, er);
        chk("sw_err", 32'(er), 32'd0);

        set_word(32'h10, 32'h80FF_0000);
        run_op(1'b0, 3'b000, 32'h13, 32'h0, 0, 0, rd, er);
        chk("lb_data", rd, 32'hFFFF_FF80);
        run_op(1'b0, 3'b100, 32'h13, 32'h0, 0, 0, rd, er);
        chk("lbu_data", rd, 32'h0000_0080);

        run_op(1'b1, 3'b001, 32'h22, 32'h0000_1234, 0, 0, rd, er);
        chk("sh_err", 32'(er), 32'd0);

        set_word(32'h40, 32'h4433_2211);
        set_word(32'h44, 32'h8877_6655);
        run_op(1'b0, 3'b010, 32'h41, 32'h0, 0, 0, rd, er);
`ifdef LSU_MISALIGNED_EN
        chk("lw_cross_data", rd, 32'h5544_3322);
`else
        chk("lw_mis_err", 32'(er), 32'd1);
`endif

        run_op(1'b0, 3'b011, 32'h50, 32'h0, 0, 0, rd, er);
        chk("f3_011_err", 32'(er), 32'd1);
        chk("f3_011_data", rd, 32'd0);

        set_word(32'h80, 32'h1357_9BDF);
        run_op(1'b0, 3'b010, 32'h80, 32'h0, 3, 0, rd, er);
        chk("lw_slow_gnt", rd, 32'h1357_9BDF);

        @(posedge clk); #1;
        chk("pre_rst_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h100;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("mid_mem_req", 32'(bus.mem_req), 32'd1);
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        chk("mid_first_ready", 32'(bus.req_ready), 32'd0);

        run_op(1'b0, 3'b010, 32'h80, 32'h0, 0, 0, rd, er);
        chk("lw_after_rst", rd, 32'h1357_9BDF);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0)
                a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else
                a = 32'($urandom_range(0, 255));
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                   $urandom, -1, -1, rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
